// File: rtl/uart_master_pkg.sv
// Shared constants for the UART echo master: 16550 register map, init values, LSR bits, FSM states.
// No logic; the ack watchdog is enabled in wb_single_xfer by UART_ECHO_TIMEOUT_EN.
package uart_master_pkg;

  localparam logic [2:0] UART_REG_RB_THR  = 3'd0;  // RBR / THR / DLL
  localparam logic [2:0] UART_REG_IER_DLM = 3'd1;
  localparam logic [2:0] UART_REG_FCR     = 3'd2;
  localparam logic [2:0] UART_REG_LCR     = 3'd3;
  localparam logic [2:0] UART_REG_LSR     = 3'd5;

  localparam logic [7:0] LCR_DLAB_INIT = 8'h83;
  localparam logic [7:0] LCR_8N1       = 8'h03;
  localparam logic [7:0] FCR_INIT      = 8'h07;
  localparam logic [7:0] IER_INIT      = 8'h00;
  localparam logic [2:0] INIT_LAST     = 3'd5;

  localparam int LSR_DR      = 0;
  localparam int LSR_ERR_LSB = 1;
  localparam int LSR_ERR_MSB = 4;
  localparam int LSR_THRE    = 5;

  typedef enum logic [2:0] {
    ST_INIT_WR   = 3'd0,
    ST_POLL_RX   = 3'd1,
    ST_READ_RBR  = 3'd2,
    ST_POLL_TX   = 3'd3,
    ST_WRITE_THR = 3'd4
  } state_e;

  typedef struct packed {
    logic [2:0] adr;
    logic [7:0] dat;
  } reg_wr_t;

  function automatic reg_wr_t init_step(input logic [2:0] idx, input logic [15:0] divisor);
    reg_wr_t w;
    case (idx)
      3'd0:    w = '{adr: UART_REG_LCR,     dat: LCR_DLAB_INIT};
      3'd1:    w = '{adr: UART_REG_RB_THR,  dat: divisor[7:0]};
      3'd2:    w = '{adr: UART_REG_IER_DLM, dat: divisor[15:8]};
      3'd3:    w = '{adr: UART_REG_LCR,     dat: LCR_8N1};
      3'd4:    w = '{adr: UART_REG_FCR,     dat: FCR_INIT};
      default: w = '{adr: UART_REG_IER_DLM, dat: IER_INIT};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// One Wishbone classic read/write; bus signals registered, cycle ends the edge after ack (or watchdog expiry).
// Accepts a new request only while idle, so every access is followed by at least one idle cycle.
// Watchdog present only when UART_ECHO_TIMEOUT_EN is defined.
module wb_single_xfer
  import uart_master_pkg::*;
#(
  parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_vld,
  input  logic       req_we,
  input  logic [2:0] req_adr,
  input  logic [7:0] req_dat,
  output logic       done_o,
  output logic       timeout_o,
  output logic [7:0] rsp_dat,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  logic       cyc_d, cyc_q, we_d, we_q;
  logic [2:0] adr_d, adr_q;
  logic [7:0] dat_d, dat_q;
  logic       expire;

`ifdef UART_ECHO_TIMEOUT_EN
  logic [7:0] wait_d, wait_q;
  // ack wins over expiry when both land on the same edge
  assign expire = cyc_q && !wb_ack_i && (wait_q == ACK_TIMEOUT - 8'd1);
  assign wait_d = (cyc_q && !wb_ack_i) ? wait_q + 8'd1 : 8'd0;
  always_ff @(posedge clk) begin
    if (rst) wait_q <= 8'd0;
    else     wait_q <= wait_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^ACK_TIMEOUT;
  assign expire = 1'b0;
`endif

  always_comb begin
    cyc_d = cyc_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (cyc_q) begin
      if (wb_ack_i || expire) cyc_d = 1'b0;
    end else if (req_vld) begin
      cyc_d = 1'b1;
      we_d  = req_we;
      adr_d = req_adr;
      dat_d = req_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= 3'd0;
      dat_q <= 8'd0;
    end else begin
      cyc_q <= cyc_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  assign done_o    = cyc_q && wb_ack_i;
  assign timeout_o = expire;
  assign rsp_dat   = wb_dat_i;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;

endmodule

// File: rtl/uart_wb_echo_master.sv
// Wishbone initiator that configures a 16550 UART and echoes every received byte back out.
// 3 cycles per register access with a single-cycle-ack slave; stalls on the slave's ack.
// UART_ECHO_TIMEOUT_EN adds an ack watchdog that abandons the cycle and flags err_o.
module uart_wb_echo_master
  import uart_master_pkg::*;
#(
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic [2:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
  output logic        init_done_o,
  output logic [7:0]  rx_byte_o,
  output logic        rx_valid_o,
  output logic        err_o,
  output logic [15:0] echo_cnt_o
);

  state_e      state_d, state_q;
  logic [2:0]  init_idx_d, init_idx_q;
  logic        init_done_d, init_done_q;
  logic [7:0]  rx_byte_d, rx_byte_q;
  logic        rx_valid_d, rx_valid_q;
  logic        err_d, err_q;
  logic [15:0] echo_cnt_d, echo_cnt_q;

  logic        req_we;
  logic [2:0]  req_adr;
  logic [7:0]  req_dat;
  reg_wr_t     init_wr;
  logic        xfer_done, xfer_timeout;
  logic [7:0]  xfer_rdat;
  logic        line_err;

  assign init_wr  = init_step(init_idx_q, DIVISOR);
  assign line_err = |xfer_rdat[LSR_ERR_MSB:LSR_ERR_LSB];

  always_comb begin
    req_we  = 1'b0;
    req_adr = UART_REG_LSR;
    req_dat = 8'h00;
    case (state_q)
      ST_INIT_WR: begin
        req_we  = 1'b1;
        req_adr = init_wr.adr;
        req_dat = init_wr.dat;
      end
      ST_READ_RBR:  req_adr = UART_REG_RB_THR;
      ST_WRITE_THR: begin
        req_we  = 1'b1;
        req_adr = UART_REG_RB_THR;
        req_dat = rx_byte_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    err_d       = err_q;
    echo_cnt_d  = echo_cnt_q;
    if (xfer_timeout) begin
      // an abandoned init write is simply reissued; anything else restarts polling
      err_d = 1'b1;
      if (state_q != ST_INIT_WR) state_d = ST_POLL_RX;
    end else if (xfer_done) begin
      case (state_q)
        ST_INIT_WR: begin
          if (init_idx_q == INIT_LAST) begin
            init_done_d = 1'b1;
            state_d     = ST_POLL_RX;
          end else begin
            init_idx_d = init_idx_q + 3'd1;
          end
        end
        ST_POLL_RX: begin
          if (line_err) err_d = 1'b1;
          if (xfer_rdat[LSR_DR]) state_d = ST_READ_RBR;
        end
        ST_READ_RBR: begin
          rx_byte_d  = xfer_rdat;
          rx_valid_d = 1'b1;
          state_d    = ST_POLL_TX;
        end
        ST_POLL_TX: begin
          if (line_err) err_d = 1'b1;
          if (xfer_rdat[LSR_THRE]) state_d = ST_WRITE_THR;
        end
        default: begin
          echo_cnt_d = echo_cnt_q + 16'd1;
          state_d    = ST_POLL_RX;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_INIT_WR;
      init_idx_q  <= 3'd0;
      init_done_q <= 1'b0;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      echo_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      err_q       <= err_d;
      echo_cnt_q  <= echo_cnt_d;
    end
  end

  wb_single_xfer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_xfer (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .req_vld   (1'b1),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_dat   (req_dat),
    .done_o    (xfer_done),
    .timeout_o (xfer_timeout),
    .rsp_dat   (xfer_rdat),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i)
  );

  assign wb_sel_o    = wb_cyc_o ? 4'b0001 : 4'b0000;
  assign init_done_o = init_done_q;
  assign rx_byte_o   = rx_byte_q;
  assign rx_valid_o  = rx_valid_q;
  assign err_o       = err_q;
  assign echo_cnt_o  = echo_cnt_q;

endmodule

// File: tb/tb_uart_wb_echo_master.sv
// Bench for uart_wb_echo_master: a behavioural 16550 slave (registered ack, RX queue, THRE delay)
// plus a transaction log and protocol monitor; expected echoes come from a byte-level model.
module tb_uart_wb_echo_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  adr;
  logic [7:0]  dat_o;
  logic [7:0]  dat_i = 8'h00;
  logic        we, stb, cyc;
  logic [3:0]  sel;
  logic        ack = 1'b0;
  logic        init_done, rx_valid, err;
  logic [7:0]  rx_byte;
  logic [15:0] echo_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_wb_echo_master dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_adr_o   (adr),
    .wb_dat_o   (dat_o),
    .wb_dat_i   (dat_i),
    .wb_we_o    (we),
    .wb_stb_o   (stb),
    .wb_cyc_o   (cyc),
    .wb_sel_o   (sel),
    .wb_ack_i   (ack),
    .init_done_o(init_done),
    .rx_byte_o  (rx_byte),
    .rx_valid_o (rx_valid),
    .err_o      (err),
    .echo_cnt_o (echo_cnt)
  );

  // slave model state
  logic       ack_en = 1'b1;
  logic [7:0] rx_q[$];
  logic [3:0] lsr_err_pend = 4'h0;
  int         thre_wait = 0;

  // transaction log and monitor state
  logic       log_we[$];
  logic [2:0] log_adr[$];
  logic [7:0] log_dat[$];
  int         log_start[$];
  int         log_ack[$];
  logic [7:0] rxv_q[$];
  int         cyc_count = 0;
  int         cur_start = 0;
  int         proto_err = 0;
  int         exp_echo = 0;
  logic       in_cyc = 1'b0, p_cyc = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_rxv = 1'b0;
  logic [2:0] p_adr = 3'd0;
  logic [7:0] p_dat = 8'h00;

  always @(posedge clk) begin
    logic [7:0] lsr;
    if (rst) begin
      ack <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (ack_en && cyc && stb && !ack) begin
        ack <= 1'b1;
        if (!we) begin
          if (adr == 3'd5) begin
            lsr = {1'b0, thre_wait == 0, thre_wait == 0, lsr_err_pend, rx_q.size() != 0};
            dat_i <= lsr;
            lsr_err_pend = 4'h0;
            if (thre_wait > 0) thre_wait--;
          end else if (adr == 3'd0 && rx_q.size() != 0) begin
            dat_i <= rx_q.pop_front();
          end else begin
            dat_i <= 8'h00;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc_count++;
    if (!rst) begin
      if (cyc !== stb) proto_err++;
      if (sel !== (cyc ? 4'b0001 : 4'b0000)) proto_err++;
      if (p_cyc && !p_ack && cyc && ({we, adr, dat_o} !== {p_we, p_adr, p_dat})) proto_err++;
      if (p_cyc && p_ack && cyc) proto_err++;
      if (rx_valid && p_rxv) proto_err++;
      if (cyc && !in_cyc) cur_start = cyc_count;
      if (cyc && ack) begin
        log_we.push_back(we);
        log_adr.push_back(adr);
        log_dat.push_back(we ? dat_o : dat_i);
        log_start.push_back(cur_start);
        log_ack.push_back(cyc_count);
      end
      if (rx_valid) rxv_q.push_back(rx_byte);
    end
    in_cyc = cyc;
    p_cyc  = cyc;
    p_ack  = ack;
    p_we   = we;
    p_adr  = adr;
    p_dat  = dat_o;
    p_rxv  = rx_valid;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear_model;
    rx_q.delete();
    lsr_err_pend = 4'h0;
    thre_wait = 0;
    log_we.delete(); log_adr.delete(); log_dat.delete(); log_start.delete(); log_ack.delete();
    rxv_q.delete();
    exp_echo = 0;
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (log_adr.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  function automatic int count_thr(input int from);
    int c = 0;
    for (int i = from; i < log_adr.size(); i++)
      if (log_we[i] && log_adr[i] == 3'd0) c++;
    return c;
  endfunction

  function automatic int first_thr(input int from);
    for (int i = from; i < log_adr.size(); i++)
      if (log_we[i] && log_adr[i] == 3'd0) return i;
    return -1;
  endfunction

  task automatic wait_thr(input int from, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (count_thr(from) >= 1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input logic [3:0] e, input int tw);
    @(negedge clk);
    rx_q.push_back(b);
    lsr_err_pend = lsr_err_pend | e;
    thre_wait = tw;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ack_en = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cyc, stb, we, adr, dat_o, sel, init_done, rx_valid, err, rx_byte, echo_cnt} !== 45'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0",
               {cyc, stb, we, adr, dat_o, sel, init_done, rx_valid, err, rx_byte, echo_cnt});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({cyc, stb, sel} !== 6'b11_0001) begin
      failures++;
      $display("FAIL first_cycle_start: cyc/stb/sel=%b required 110001", {cyc, stb, sel});
    end
  endtask

  task automatic test_init;
    logic [2:0] ea [6];
    logic [7:0] ed [6];
    bit ok;
    ea = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
    ed = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07, 8'h00};
    wait_log(5, 100, ok);
    checks++;
    if (!ok || init_done !== 1'b0) begin
      failures++;
      $display("FAIL init_done_early: ok=%0d init_done=%b required ok=1 init_done=0", ok, init_done);
    end
    wait_log(6, 100, ok);
    checks++;
    if (!ok || init_done !== 1'b1) begin
      failures++;
      $display("FAIL init_done_set: ok=%0d init_done=%b required 1", ok, init_done);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (!ok || log_we[i] !== 1'b1 || log_adr[i] !== ea[i] || log_dat[i] !== ed[i]) begin
        failures++;
        $display("FAIL init_write_%0d: we=%b adr=%0d dat=%h required we=1 adr=%0d dat=%h",
                 i, ok ? log_we[i] : 1'bx, ok ? log_adr[i] : 3'bx, ok ? log_dat[i] : 8'hxx, ea[i], ed[i]);
      end
    end
    checks++;
    if (!ok || (log_ack[5] - log_ack[0]) != 15) begin
      failures++;
      $display("FAIL init_pacing: ack span=%0d cycles required 15", ok ? log_ack[5] - log_ack[0] : -1);
    end
  endtask

  task automatic test_echo;
    logic [7:0] b;
    int tw, start, t, j, rxv_base;
    bit ok;
    rxv_base = rxv_q.size();
    for (int k = 0; k < 8; k++) begin
      b  = (k == 0) ? 8'h5A : 8'($urandom_range(0, 255));
      tw = (k == 0) ? 0 : int'($urandom_range(0, 3));
      start = log_adr.size();
      push_byte(b, 4'h0, tw);
      wait_thr(start, 300, ok);
      exp_echo++;
      t = first_thr(start);
      checks++;
      if (!ok || t < 0 || log_dat[t] !== b) begin
        failures++;
        $display("FAIL echo_data_%0d: got %h required %h", k, (t >= 0) ? log_dat[t] : 8'hxx, b);
      end
      checks++;
      if (rxv_q.size() != rxv_base + k + 1 || rxv_q[rxv_q.size()-1] !== b) begin
        failures++;
        $display("FAIL rx_valid_%0d: pulses=%0d required %0d, byte required %h",
                 k, rxv_q.size() - rxv_base, k + 1, b);
      end
      checks++;
      if (echo_cnt !== 16'(exp_echo)) begin
        failures++;
        $display("FAIL echo_cnt_%0d: got %0d required %0d", k, echo_cnt, exp_echo);
      end
      if (k == 0) begin
        j = -1;
        for (int i = start; i < log_adr.size(); i++)
          if (j < 0 && !log_we[i] && log_adr[i] == 3'd5 && log_dat[i][0]) j = i;
        checks++;
        if (j < 0 || j + 1 >= log_adr.size() || log_we[j+1] || log_adr[j+1] !== 3'd0 ||
            log_dat[j+1] !== b || log_dat[j] !== 8'h61 || (log_start[j+1] - log_ack[j]) != 2) begin
          failures++;
          $display("FAIL rbr_after_lsr: lsr_idx=%0d rbr start offset=%0d required LSR 61 then RBR 5A at offset 2",
                   j, (j >= 0 && j + 1 < log_adr.size()) ? log_start[j+1] - log_ack[j] : -1);
        end
        checks++;
        if (j < 0 || t < 0 || (log_start[t] - log_ack[j]) < 7) begin
          failures++;
          $display("FAIL thr_latency: offset=%0d required >= 7",
                   (j >= 0 && t >= 0) ? log_start[t] - log_ack[j] : -1);
        end
      end
    end
  endtask

  task automatic test_thre_wait;
    logic [7:0] b;
    int start, t, busy;
    bit ok;
    b = 8'($urandom_range(0, 255));
    start = log_adr.size();
    push_byte(b, 4'h0, 20);
    wait_thr(start, 400, ok);
    exp_echo++;
    repeat (40) @(posedge clk);
    #1;
    t = first_thr(start);
    busy = 0;
    for (int i = start; i < log_adr.size(); i++)
      if (!log_we[i] && log_adr[i] == 3'd5 && !log_dat[i][5]) busy++;
    checks++;
    if (!ok || count_thr(start) != 1) begin
      failures++;
      $display("FAIL thre_write_count: got %0d required 1", count_thr(start));
    end
    checks++;
    if (busy != 20) begin
      failures++;
      $display("FAIL thre_busy_polls: got %0d required 20", busy);
    end
    checks++;
    if (t < 1 || log_we[t-1] || log_adr[t-1] !== 3'd5 || !log_dat[t-1][5] || log_dat[t] !== b) begin
      failures++;
      $display("FAIL thre_order: idx=%0d data=%h required write of %h after a THRE=1 poll",
               t, (t >= 0) ? log_dat[t] : 8'hxx, b);
    end
    checks++;
    if (echo_cnt !== 16'(exp_echo)) begin
      failures++;
      $display("FAIL thre_echo_cnt: got %0d required %0d", echo_cnt, exp_echo);
    end
  endtask

  task automatic test_line_error;
    logic [7:0] b;
    int start, t;
    bit ok;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_clean: got %b required 0", err);
    end
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom_range(0, 255));
      start = log_adr.size();
      push_byte(b, (k == 0) ? 4'b0100 : 4'b0000, 0);
      wait_thr(start, 300, ok);
      exp_echo++;
      t = first_thr(start);
      checks++;
      if (!ok || t < 0 || log_dat[t] !== b || echo_cnt !== 16'(exp_echo)) begin
        failures++;
        $display("FAIL line_err_echo_%0d: data=%h cnt=%0d required data=%h cnt=%0d",
                 k, (t >= 0) ? log_dat[t] : 8'hxx, echo_cnt, b, exp_echo);
      end
      checks++;
      if (err !== 1'b1) begin
        failures++;
        $display("FAIL line_err_sticky_%0d: got %b required 1", k, err);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    @(negedge clk); ack_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (stb !== 1'b1) begin
      failures++;
      $display("FAIL stall_stb: got %b required 1", stb);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cyc, stb, err, init_done, echo_cnt} !== 20'd0) begin
      failures++;
      $display("FAIL reset_mid_cycle: cyc=%b stb=%b err=%b init_done=%b cnt=%0d required all 0",
               cyc, stb, err, init_done, echo_cnt);
    end
    @(negedge clk);
    clear_model();
    ack_en = 1'b1;
    rst = 1'b0;
    wait_log(1, 50, ok);
    checks++;
    if (!ok || log_we[0] !== 1'b1 || log_adr[0] !== 3'd3 || log_dat[0] !== 8'h83) begin
      failures++;
      $display("FAIL restart_first_write: adr=%0d dat=%h required adr=3 dat=83",
               ok ? log_adr[0] : 3'bx, ok ? log_dat[0] : 8'hxx);
    end
    wait_log(6, 100, ok);
    checks++;
    if (!ok || init_done !== 1'b1 || echo_cnt !== 16'd0) begin
      failures++;
      $display("FAIL restart_init: init_done=%b cnt=%0d required 1 and 0", init_done, echo_cnt);
    end
  endtask

  task automatic test_no_ack;
    int n;
    @(negedge clk);
    rst = 1'b1;
    ack_en = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cyc !== 1'b1 || adr !== 3'd3 || dat_o !== 8'h83) begin
      failures++;
      $display("FAIL noack_start: cyc=%b adr=%0d dat=%h required 1/3/83", cyc, adr, dat_o);
    end
`ifdef UART_ECHO_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!cyc) break;
      n++;
    end
    checks++;
    if (n + 1 != 255 || err !== 1'b1) begin
      failures++;
      $display("FAIL ack_timeout: cyc high %0d cycles err=%b required 255 and 1", n + 1, err);
    end
    @(posedge clk); #1;
    checks++;
    if (cyc !== 1'b1 || we !== 1'b1 || adr !== 3'd3 || dat_o !== 8'h83) begin
      failures++;
      $display("FAIL timeout_retry: cyc=%b we=%b adr=%0d dat=%h required 1/1/3/83", cyc, we, adr, dat_o);
    end
`else
    n = 0;
    repeat (600) @(posedge clk);
    #1;
    checks++;
    if (cyc !== 1'b1 || adr !== 3'd3 || dat_o !== 8'h83 || err !== 1'b0 || log_adr.size() != n) begin
      failures++;
      $display("FAIL wait_forever: cyc=%b adr=%0d dat=%h err=%b required 1/3/83/0", cyc, adr, dat_o, err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_init();
    test_echo();
    test_thre_wait();
    test_line_error();
    test_reset_mid();
    test_no_ack();
    checks++;
    if (proto_err != 0) begin
      failures++;
      $display("FAIL bus_protocol: %0d violations required 0", proto_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_wb_echo_master.md
# uart_wb_echo_master

Wishbone classic initiator that drives the 16550-compatible `uart_top` register file from the fabric side. It is the counterpart of the UART's slave port. After reset it programs the divisor latch and line control, then loops forever:
- polls the Line Status Register;
- reads each received byte;
- writes it back to the transmit holding register once THR is empty.

Received bytes and line errors are exported as status. It replaces the tied-off Wishbone inputs in the top-level wrapper and turns the chip into a self-contained serial echo device.

## Interface
Parameters:
- `DIVISOR`, 16'd27, divisor latch value written to DLL/DLM (27 gives 115200 baud at 50 MHz).
- `ACK_TIMEOUT`, 8'd255, maximum cycles to wait for `wb_ack_i` before abandoning a cycle.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `wb_adr_o` out 3: register address.
- `wb_dat_o` out 8: write data.
- `wb_dat_i` in 8: read data.
- `wb_we_o` out 1: write enable.
- `wb_stb_o` out 1: strobe.
- `wb_cyc_o` out 1: cycle.
- `wb_sel_o` out 4: byte select, constant 4'b0001 while `wb_cyc_o` is high, else 0.
- `wb_ack_i` in 1: slave acknowledge.
- `init_done_o` out 1: configuration sequence complete.
- `rx_byte_o` out 8: last byte read from RBR.
- `rx_valid_o` out 1: one-cycle pulse when `rx_byte_o` updates.
- `err_o` out 1: sticky line-error or timeout flag.
- `echo_cnt_o` out 16: bytes echoed, wraps at 0xFFFF→0.

## Operation
- Register map: 0 RBR/THR/DLL, 1 IER/DLM, 2 FCR, 3 LCR, 5 LSR.
- INIT phase, six writes in this order:
  - LCR=0x83;
  - DLL=`DIVISOR[7:0]`;
  - DLM=`DIVISOR[15:8]`;
  - LCR=0x03 (8N1, DLAB=0);
  - FCR=0x07;
  - IER=0x00.
- After the last INIT ack, `init_done_o` goes high and stays high until reset.
- States: INIT_WR → POLL_RX → READ_RBR → POLL_TX → WRITE_THR → POLL_RX.
- POLL_RX: read LSR.
  - If LSR[4:1]≠0, set `err_o`.
  - If LSR[0]=1, go to READ_RBR; otherwise re-poll.
- READ_RBR:
  - Latch `wb_dat_i` into `rx_byte_o` and pulse `rx_valid_o` on the ack cycle.
  - Go to POLL_TX.
- POLL_TX: read LSR until LSR[5]=1, then go to WRITE_THR.
- WRITE_THR:
  - Write `rx_byte_o` to address 0.
  - Increment `echo_cnt_o` on ack.
  - Go to POLL_RX.
- Line errors seen in POLL_TX also set `err_o`. The byte is still echoed; no retry.
- Ack timeout:
  - When `ACK_TIMEOUT` cycles pass without ack, drop cyc/stb and set `err_o`.
  - In INIT, retry the same write.
  - Elsewhere, go to POLL_RX without incrementing the counter and without pulsing `rx_valid_o`.
- Reset at any point, including mid-cycle: cyc/stb drop next edge and the sequence restarts from the first INIT write.

## Timing
- Reset values: all outputs 0, except `wb_sel_o`=0.
- The first INIT cycle asserts `wb_cyc_o`/`wb_stb_o` on the first edge after `wb_rst_i` falls.
- Cycle rules:
  - cyc, stb, adr, we and dat_o are registered and held constant until ack is sampled.
  - They deassert on the edge after ack.
  - At least one idle cycle separates consecutive cycles.
  - cyc==stb always.
- Single-cycle ack slave: each transaction occupies 2 cycles plus 1 idle, i.e. 3 cycles per register access.
- Echo latency from LSR[0] sampled 1: READ_RBR starts 1 cycle later; THR write issues ≥6 cycles after that LSR ack.
- Ack arriving on the same edge as timeout expiry counts as success.

## Configuration
- `UART_ECHO_TIMEOUT_EN` defined: ack watchdog counter present, with behaviour as above.
- Undefined: no counter. The master waits indefinitely for ack, and `err_o` reflects line errors only.

## Structure
- Shared package `uart_master_pkg` holds:
  - register address constants (`UART_REG_RB_THR`, `UART_REG_LSR`, etc.);
  - the LCR/FCR init values;
  - LSR bit indices;
  - the state enum.
- One sub-module, `wb_single_xfer`:
  - executes one classic read or write with the idle gap and optional timeout;
  - returns done/timeout/rdata.
- The top-level FSM sequences requests to `wb_single_xfer`.

## Test plan
- Reset release with a single-cycle-ack BFM: six writes observed in order, at adr 3,0,1,3,2,1 with data 0x83,0x1B,0x00,0x03,0x07,0x00; `init_done_o`=1 after the sixth ack.
- BFM LSR=0x61 with RBR=0x5A: RBR read, then a THR write of 0x5A; `rx_valid_o` pulses once with `rx_byte_o`=0x5A; `echo_cnt_o`=1.
- LSR[5]=0 for 20 polls, then 1: no THR write before the THR-empty poll; exactly one write afterwards.
- LSR=0x09 (framing error + DR): `err_o`=1 and stays 1; the byte is still echoed.
- Slave never acks (timeout build): cyc drops after 255 cycles, `err_o`=1, the same INIT write is retried.
- Reset asserted while stb is high waiting for ack: stb=0 next edge; on release the sequence restarts at LCR=0x83 and `echo_cnt_o`=0.
